// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode encoding, 640x480 timing defaults and width helper
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK   = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  // Never returns less than 1 so a degenerate total still yields a legal vector width.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - h/v raster counters and sync/visible decode of the current position
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int HW       = clog2(H_TOTAL),
  localparam int VW       = clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hs_act,
  output logic          vs_act,
  output logic          de,
  output logic          frame_first,
  output logic          line_first
);

  localparam logic [HW-1:0] H_END  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_END  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      if (h == H_END) begin
        h <= '0;
        v <= (v == V_END) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign hs_act      = (h >= HS_BEG) && (h <= HS_END);
  assign vs_act      = (v >= VS_BEG) && (v <= VS_END);
  assign de          = (h < H_VIS) && (v < V_VIS);
  assign frame_first = (h == '0) && (v == '0);
  assign line_first  = (h == '0);

endmodule

// File: rtl/vga_timing_pattern.sv
// rtl/vga_timing_pattern.sv - VGA raster timing with test-pattern generator and aligned output registers
module vga_timing_pattern
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int CHECK_LOG2 = 5,
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int HW        = clog2(H_TOTAL),
  localparam int VW        = clog2(V_TOTAL)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b,
  output logic                    hs,
  output logic                    vs,
  output logic                    de,
  output logic [HW-1:0]           hcount,
  output logic [VW-1:0]           vcount,
  output logic                    frame_start,
  output logic                    line_start
);

  localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;

  logic [HW-1:0]           h;
  logic [VW-1:0]           v;
  logic                    hs_act, vs_act, de_c, frame_first, line_first;
  mode_e                   mode_q, mode_eff;
  logic [31:0]             bar_q;
  logic [2:0]              bar;
  logic                    chk;
  logic [3*COLOR_BITS-1:0] pix;

  vga_timing_core #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .h           (h),
    .v           (v),
    .hs_act      (hs_act),
    .vs_act      (vs_act),
    .de          (de_c),
    .frame_first (frame_first),
    .line_first  (line_first)
  );

  // The pixel at (0,0) already uses the newly sampled mode, so a frame is never split.
  assign mode_eff = frame_first ? mode_e'(mode) : mode_q;

  assign bar_q = 32'(h) / 32'(BAR_W);
  assign bar   = (bar_q > 32'd7) ? 3'd7 : bar_q[2:0];
  assign chk   = (|(32'(h) & (32'd1 << CHECK_LOG2))) ^ (|(32'(v) & (32'd1 << CHECK_LOG2)));

  always_comb begin
    pix = '0;
    if (de_c) begin
      case (mode_eff)
        MODE_SOLID:   pix = solid_rgb;
        MODE_BARS:    pix = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
        MODE_CHECKER: pix = {(3*COLOR_BITS){chk}};
        default:      pix = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      de          <= 1'b0;
      hs          <= !HS_POL;
      vs          <= !VS_POL;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      mode_q      <= MODE_BLACK;
    end else if (ce) begin
      {r, g, b}   <= pix;
      de          <= de_c;
      hs          <= hs_act ? HS_POL : !HS_POL;
      vs          <= vs_act ? VS_POL : !VS_POL;
      hcount      <= h;
      vcount      <= v;
      frame_start <= frame_first;
      line_start  <= line_first;
      mode_q      <= mode_eff;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// tb/tb_vga_timing_pattern.sv - bench for vga_timing_pattern on a 14x7 raster, both sync polarities
module tb_vga_timing_pattern;

  localparam int HV = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int CL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] solid_rgb = 12'h000;

  logic [3:0] r, g, b, r1, g1, b1, hc, hc1;
  logic [2:0] vc, vc1;
  logic       hs, vs, de, fs, ls, hs1, vs1, de1, fs1, ls1;

  always #5 clk = ~clk;

  vga_timing_pattern #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(4), .CHECK_LOG2(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .solid_rgb(solid_rgb),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de),
    .hcount(hc), .vcount(vc), .frame_start(fs), .line_start(ls)
  );

  vga_timing_pattern #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_BITS(4), .CHECK_LOG2(CL)
  ) dut_pol (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .solid_rgb(solid_rgb),
    .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1), .de(de1),
    .hcount(hc1), .vcount(vc1), .frame_start(fs1), .line_start(ls1)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        de, hs_a, vs_a, fs, ls;
    logic [3:0]  hc;
    logic [2:0]  vc;
  } exp_t;

  typedef struct {
    int          md;
    logic [11:0] sol;
    int          h, v;
    logic [11:0] rgb;
    logic        de, hs_a, vs_a;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  int   mh, mv, mmode;
  int   tests = 0, failed = 0;
  vec_t tbl[16];

  function automatic exp_t model_pix(int h, int v, int md, logic [11:0] sol);
    exp_t e;
    int   k;
    e      = '0;
    e.hc   = 4'(h);
    e.vc   = 3'(v);
    e.de   = (h < HV) && (v < VV);
    e.hs_a = (h >= HV + HF) && (h < HV + HF + HSW);
    e.vs_a = (v >= VV + VF) && (v < VV + VF + VSW);
    e.fs   = (h == 0) && (v == 0);
    e.ls   = (h == 0);
    k = h / (HV / 8);
    if (k > 7) k = 7;
    case (md)
      1: e.rgb = sol;
      2: e.rgb = {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
      3: e.rgb = (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 12'hFFF : 12'h000;
      default: e.rgb = 12'h000;
    endcase
    if (!e.de) e.rgb = 12'h000;
    return e;
  endfunction

  task automatic check_all(input string name, input exp_t e);
    logic ok;
    tests++;
    ok = ({r, g, b} === e.rgb) && (de === e.de) && (hs === !e.hs_a) && (vs === !e.vs_a) &&
         (fs === e.fs) && (ls === e.ls) && (hc === e.hc) && (vc === e.vc) &&
         ({r1, g1, b1} === e.rgb) && (de1 === e.de) && (hs1 === e.hs_a) && (vs1 === e.vs_a) &&
         (fs1 === e.fs) && (ls1 === e.ls) && (hc1 === e.hc) && (vc1 === e.vc);
    if (!ok) begin
      failed++;
      $display("FAIL %s t=%0t: got rgb=%h de=%b hs=%b vs=%b fs=%b ls=%b h=%0d v=%0d pol1(rgb=%h hs=%b vs=%b) expected rgb=%h de=%b hs_act=%b vs_act=%b fs=%b ls=%b h=%0d v=%0d",
               name, $time, {r, g, b}, de, hs, vs, fs, ls, hc, vc, {r1, g1, b1}, hs1, vs1,
               e.rgb, e.de, e.hs_a, e.vs_a, e.fs, e.ls, e.hc, e.vc);
    end
  endtask

  task automatic check_eq(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      failed++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, expv);
    end
  endtask

  task automatic step(input logic ce_v);
    exp_t e;
    ce = ce_v;
    if (ce_v) begin
      if (mh == 0 && mv == 0) mmode = int'(mode);
      cur = model_pix(mh, mv, mmode, solid_rgb);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_all("scoreboard", e);
  endtask

  // Called one time unit after a rising edge: the first check lands before any further edge.
  task automatic do_reset();
    rst_n = 1'b0;
    mh = 0; mv = 0; mmode = 0;
    cur = '0;
    #2;
    check_all("reset_async", cur);
    @(posedge clk);
    #1;
    check_all("reset_hold", cur);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_a, fs_b, ls_a, ls_b, hs_bad, vs_bad, cyc;
    logic fs_p, ls_p;

    tbl[0]  = '{0, 12'h000,  3, 1, 12'h000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1, 12'hA5C,  3, 1, 12'hA5C, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1, 12'h123,  9, 1, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2, 12'h000,  5, 0, 12'hF0F, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{2, 12'h000,  0, 2, 12'h000, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{2, 12'h000,  7, 3, 12'hFFF, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{2, 12'h000,  6, 3, 12'hFF0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{3, 12'h000,  2, 0, 12'hFFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{3, 12'h000,  2, 2, 12'h000, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3, 12'h000,  1, 2, 12'hFFF, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1, 12'hFFF, 10, 0, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1, 12'hFFF, 11, 5, 12'h000, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1, 12'hFFF, 12, 5, 12'h000, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1, 12'h777,  0, 0, 12'h777, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{3, 12'h000, 13, 6, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1, 12'hFFF,  0, 4, 12'h000, 1'b0, 1'b0, 1'b0};

    #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      exp_t te;
      do_reset();
      mode = 2'(tbl[i].md);
      solid_rgb = tbl[i].sol;
      for (int n = 0; n <= tbl[i].v * HT + tbl[i].h; n++) step(1'b1);
      te      = '0;
      te.rgb  = tbl[i].rgb;
      te.de   = tbl[i].de;
      te.hs_a = tbl[i].hs_a;
      te.vs_a = tbl[i].vs_a;
      te.fs   = (tbl[i].h == 0) && (tbl[i].v == 0);
      te.ls   = (tbl[i].h == 0);
      te.hc   = 4'(tbl[i].h);
      te.vc   = 3'(tbl[i].v);
      check_all($sformatf("table_%0d", i), te);
    end

    // Continuous ce: pulse periods and sync windows.
    do_reset();
    mode = 2'd1;
    solid_rgb = 12'h0F0;
    fs_a = -1; fs_b = -1; ls_a = -1; ls_b = -1; hs_bad = 0; vs_bad = 0;
    fs_p = 1'b0; ls_p = 1'b0;
    for (cyc = 1; cyc <= 250; cyc++) begin
      step(1'b1);
      if (fs && !fs_p) begin if (fs_a < 0) fs_a = cyc; else if (fs_b < 0) fs_b = cyc; end
      if (ls && !ls_p) begin if (ls_a < 0) ls_a = cyc; else if (ls_b < 0) ls_b = cyc; end
      fs_p = fs; ls_p = ls;
      if ((hs == 1'b0) != (hc >= 4'd10 && hc <= 4'd11)) hs_bad++;
      if ((vs == 1'b0) != (vc == 3'd5)) vs_bad++;
    end
    check_eq("frame_period_ce1", fs_b - fs_a, 98);
    check_eq("line_period_ce1", ls_b - ls_a, 14);
    check_eq("hs_window_bad", hs_bad, 0);
    check_eq("vs_window_bad", vs_bad, 0);

    // Alternating ce: periods double, scoreboard covers the hold cycles.
    do_reset();
    fs_a = -1; fs_b = -1; ls_a = -1; ls_b = -1;
    fs_p = 1'b0; ls_p = 1'b0;
    for (cyc = 1; cyc <= 420; cyc++) begin
      step((cyc % 2) == 1);
      if (fs && !fs_p) begin if (fs_a < 0) fs_a = cyc; else if (fs_b < 0) fs_b = cyc; end
      if (ls && !ls_p) begin if (ls_a < 0) ls_a = cyc; else if (ls_b < 0) ls_b = cyc; end
      fs_p = fs; ls_p = ls;
    end
    check_eq("frame_period_toggle", fs_b - fs_a, 196);
    check_eq("line_period_toggle", ls_b - ls_a, 28);

    // Mode change mid-frame waits for the next frame.
    do_reset();
    mode = 2'd1;
    solid_rgb = 12'h3C5;
    for (int n = 0; n <= 32; n++) step(1'b1);
    check_eq("mode_chg_pos", {hc, 1'b0, vc}, {4'd4, 1'b0, 3'd2});
    mode = 2'd3;
    for (int idx = 33; idx <= 100; idx++) begin
      step(1'b1);
      if (idx == 45) check_eq("mode_hold_rgb", {r, g, b}, 12'h3C5);
      if (idx == 100) begin
        check_eq("mode_new_pos", {hc, 1'b0, vc}, {4'd2, 1'b0, 3'd0});
        check_eq("mode_new_rgb", {r, g, b}, 12'hFFF);
      end
    end

    // Asynchronous reset mid-line and clean restart.
    do_reset();
    mode = 2'd1;
    solid_rgb = 12'hABC;
    for (int n = 0; n <= 20; n++) step(1'b1);
    check_eq("pre_reset_h", hc, 6);
    do_reset();
    step(1'b1);
    check_eq("restart_fs", fs, 1);
    check_eq("restart_h", hc, 0);
    check_eq("restart_v", vc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_pattern.md
VGA_TIMING_PATTERN -- requirements
Module: vga_timing_pattern

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameters V_VISIBLE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, in lines.
REQ-006 The block SHALL have parameters HS_POL and VS_POL, default 0, giving the asserted sync level.
REQ-007 The block SHALL have parameter COLOR_BITS, default 4, bits per colour channel.
REQ-008 The block SHALL have parameter CHECK_LOG2, default 5, giving a checker square edge of 2^CHECK_LOG2 pixels.
REQ-009 clk  input  1  pixel clock; all logic is on its rising edge.
REQ-010 rst_n  input  1  reset; asynchronous assert, active-low (already decided).
REQ-011 ce  input  1  pixel enable; the state advances only on cycles where ce=1.
REQ-012 mode  input  2  pattern select: 0 black, 1 solid, 2 colour bars, 3 checker.
REQ-013 solid_rgb  input  3*COLOR_BITS  colour for mode 1, packed {r,g,b}.
REQ-014 r, g, b  output  COLOR_BITS each  pixel colour.
REQ-015 hs, vs  output  1 each  sync signals, asserted at HS_POL/VS_POL.
REQ-016 de  output  1  high on visible pixels.
REQ-017 hcount, vcount  output  clog2(H_TOTAL), clog2(V_TOTAL)  position of the pixel currently presented.
REQ-018 frame_start  output  1  one-ce pulse on pixel (0,0); line_start  output  1  one-ce pulse on h=0 of every line.

Function
REQ-019 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP and V_TOTAL is formed the same way; all count arithmetic SHALL be unsigned and modulo the total.
REQ-020 On each ce cycle, h SHALL increment, and at h = H_TOTAL-1 it SHALL wrap to 0 and v SHALL increment; at v = V_TOTAL-1 with the h wrap, v SHALL wrap to 0.
REQ-021 hsync SHALL be asserted for h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]; vsync SHALL be asserted for v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], for whole lines.
REQ-022 de SHALL equal (h<H_VISIBLE)&&(v<V_VISIBLE).
REQ-023 All outputs SHALL be registered with exactly one ce-cycle latency from the counter state, so rgb, de, hs, vs, hcount, vcount and the pulse outputs stay mutually aligned.
REQ-024 When ce=0, all outputs SHALL hold their values.
REQ-025 rgb SHALL be 0 whenever de=0, in every mode.
REQ-026 In mode 1, rgb SHALL equal solid_rgb.
REQ-027 In mode 2, the visible width SHALL be split into 8 bars of width H_VISIBLE/8 (integer division), with bar index k driving every bit of r with k[2], every bit of g with k[1] and every bit of b with k[0]; pixels beyond 8*(H_VISIBLE/8) SHALL use bar 7.
REQ-028 In mode 3, the pixel SHALL be all-ones when h[CHECK_LOG2]^v[CHECK_LOG2]=1, otherwise 0.
REQ-029 mode SHALL be sampled only at the ce cycle where h=0 and v=0, so that a mode change never takes effect mid-frame; solid_rgb SHALL be used live.

Reset
REQ-030 While rst_n=0: h=v=0, hcount=vcount=0, rgb=0, de=0, frame_start=line_start=0, hs=!HS_POL, vs=!VS_POL, latched mode=0.
REQ-031 After rst_n is released, the first ce cycle SHALL present pixel (0,0) with frame_start=1, with no partial frame.
REQ-032 An assertion of reset mid-line SHALL take effect immediately and asynchronously, and the restart SHALL follow REQ-031.

Structure
REQ-033 Package vga_pkg SHALL hold the mode enumeration, the 640x480 default timing constants, and a clog2 helper function.
REQ-034 The counters and sync decode SHALL reside in sub-module vga_timing_core; pattern generation and output registers SHALL reside in the top level.

Verification (bench parameters 8/2/2/2, 4/1/1/1, H_TOTAL=14, V_TOTAL=7, CHECK_LOG2=1)
REQ-035 ce=1 constantly -> frame_start period is 98 clk; line_start period is 14; hs asserted for hcount 10..11; vs asserted on vcount 5 only.
REQ-036 ce toggling 1/0 -> all periods double, and outputs are unchanged on ce=0 cycles.
REQ-037 mode=2 -> bars of width 1; hcount=5 gives r=0xF, g=0x0, b=0xF; de=0 gives rgb=0.
REQ-038 mode changes from 1 to 3 at hcount=4, vcount=2 -> mode 1 persists until the next frame_start, then pixel (2,0) is 0xFFF.
REQ-039 rst_n pulsed low at hcount=6 -> outputs go to reset values without a clk edge; first ce after release gives frame_start=1, hcount=0, vcount=0.
REQ-040 HS_POL=1, VS_POL=1 -> hs and vs are low outside the sync windows and high within them, including during reset (low).
